// File: rtl/seg_scan_decoder.sv
// Rebuilds the 32-bit hex word shown on a scanned 8-digit active-low seven-segment bus.
// Accept latency SYNC_STAGES+STABLE_CYCLES-1 after the bus settles; o_valid one cycle after the final digit; no backpressure.
module seg_scan_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [7:0]  i_seg,
   input  logic [7:0]  i_sel,
   output logic [31:0] o_value,
   output logic [7:0]  o_dp,
   output logic        o_valid,
   output logic        o_err
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic {WAIT, HOLD} state_t;

   logic [7:0]    sel_sync [SYNC_STAGES];
   logic [7:0]    seg_sync [SYNC_STAGES];
   logic [7:0]    prev_sel, prev_seg, seen, dpsh;
   logic [31:0]   shadow;
   logic [CW-1:0] cnt, cnt_nxt;
   state_t        state;
   logic          done;

   logic [7:0] s_sel, s_seg, sel_a, seen_nxt;
   logic       legal, same, accept;
   logic [2:0] idx;
   logic [4:0] dec;

   // {valid, nibble} for an active-high gfedcba pattern
   function automatic logic [4:0] dec7(input logic [6:0] p);
      case (p)
         7'h3F: dec7 = 5'h10;  7'h06: dec7 = 5'h11;
         7'h5B: dec7 = 5'h12;  7'h4F: dec7 = 5'h13;
         7'h66: dec7 = 5'h14;  7'h6D: dec7 = 5'h15;
         7'h7D: dec7 = 5'h16;  7'h07: dec7 = 5'h17;
         7'h7F: dec7 = 5'h18;  7'h6F: dec7 = 5'h19;
         7'h77: dec7 = 5'h1A;  7'h7C: dec7 = 5'h1B;
         7'h39: dec7 = 5'h1C;  7'h5E: dec7 = 5'h1D;
         7'h79: dec7 = 5'h1E;  7'h71: dec7 = 5'h1F;
         default: dec7 = 5'h00;
      endcase
   endfunction

   always_comb begin
      s_sel   = sel_sync[SYNC_STAGES-1];
      s_seg   = seg_sync[SYNC_STAGES-1];
      sel_a   = ~s_sel;
      legal   = (sel_a != 8'd0) && ((sel_a & (sel_a - 8'd1)) == 8'd0);
      same    = (s_sel == prev_sel) && (s_seg == prev_seg);
      cnt_nxt = same ? ((cnt == CNT_MAX) ? cnt : cnt + CNT_ONE) : CNT_ONE;
      accept  = legal && (state == WAIT) && (cnt_nxt == CNT_MAX);
      dec     = dec7(~s_seg[6:0]);
      idx     = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (sel_a[i]) idx = 3'(i);
      seen_nxt = seen | (8'd1 << idx);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sel_sync[i] <= 8'hFF;
            seg_sync[i] <= 8'hFF;
         end
         prev_sel <= 8'hFF;
         prev_seg <= 8'hFF;
         seen     <= 8'd0;
         dpsh     <= 8'd0;
         shadow   <= 32'd0;
         cnt      <= '0;
         state    <= WAIT;
         done     <= 1'b0;
         o_value  <= 32'd0;
         o_dp     <= 8'd0;
         o_valid  <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         sel_sync[0] <= i_sel;
         seg_sync[0] <= i_seg;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sel_sync[i] <= sel_sync[i-1];
            seg_sync[i] <= seg_sync[i-1];
         end
         prev_sel <= s_sel;
         prev_seg <= s_seg;

         // publish the frame completed by the previous cycle's accept
         o_valid <= done;
         done    <= 1'b0;
         if (done) begin
            o_value <= shadow;
            o_dp    <= dpsh;
            seen    <= 8'd0;
         end

         if (!legal) begin
            cnt   <= '0;
            state <= WAIT;
         end else if (state == WAIT) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == CNT_MAX) state <= HOLD;
         end else if (!same) begin
            cnt   <= CNT_ONE;
            state <= WAIT;
         end

         if (accept) begin
            if (dec[4]) begin
               shadow[{idx, 2'b00} +: 4] <= dec[3:0];
               dpsh[idx] <= ~s_seg[7];
               seen      <= seen_nxt;
               done      <= (seen_nxt == 8'hFF);
            end else begin
               o_err <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built frames and checks decoded results.
module tb_seg_scan_decoder;
   logic        clk_in = 1'b0;
   logic        reset;
   logic [7:0]  i_seg, i_sel;
   logic [31:0] o_value;
   logic [7:0]  o_dp;
   logic        o_valid, o_err;

   int total = 0;
   int bad   = 0;
   int vcount = 0;
   int v0;

   seg_scan_decoder dut (
      .clk_in (clk_in),
      .reset  (reset),
      .i_seg  (i_seg),
      .i_sel  (i_sel),
      .o_value(o_value),
      .o_dp   (o_dp),
      .o_valid(o_valid),
      .o_err  (o_err)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in)
      if (o_valid) vcount++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic show_raw(input int k, input logic [7:0] seg_hi, input int n);
      i_sel = ~(8'd1 << k);
      i_seg = ~seg_hi;
      cycles(n);
   endtask

   task automatic show(input int k, input logic [3:0] nib, input logic dp, input int n);
      show_raw(k, {dp, seg7(nib)}, n);
   endtask

   task automatic blank(input int n);
      i_sel = 8'hFF;
      i_seg = 8'hFF;
      cycles(n);
   endtask

   task automatic send_frame(input logic [31:0] v, input logic [7:0] dp, input bit rev);
      for (int j = 0; j < 8; j++) begin
         int k;
         k = rev ? j : 7 - j;
         show(k, v[4*k +: 4], dp[k], 10);
      end
      blank(8);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      i_sel = 8'hFF;
      i_seg = 8'hFF;
      cycles(3);
      reset = 1'b0;
      cycles(1);
   endtask

   initial begin
      reset = 1'b1;
      i_sel = 8'hFF;
      i_seg = 8'hFF;
      cycles(3);
      chk("rst_value", o_value, 32'd0);
      chk("rst_dp",    {24'd0, o_dp}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_err",   {31'd0, o_err}, 32'd0);
      reset = 1'b0;
      cycles(1);

      // basic frame
      v0 = vcount;
      send_frame(32'h12345678, 8'h00, 1'b0);
      chk("t1_pulses", vcount - v0, 1);
      chk("t1_value",  o_value, 32'h12345678);
      chk("t1_dp",     {24'd0, o_dp}, 32'd0);
      chk("t1_err",    {31'd0, o_err}, 32'd0);

      // digit 3 too short on first pass
      apply_reset();
      v0 = vcount;
      for (int k = 7; k >= 0; k--) begin
         logic [31:0] v;
         v = 32'h12345678;
         show(k, v[4*k +: 4], 1'b0, (k == 3) ? 3 : 10);
      end
      blank(8);
      chk("t2_no_pulse", vcount - v0, 0);
      send_frame(32'h12345678, 8'h00, 1'b0);
      chk("t2_pulses", vcount - v0, 1);
      chk("t2_value",  o_value, 32'h12345678);

      // glitch on digit 0
      apply_reset();
      v0 = vcount;
      for (int k = 7; k >= 1; k--) begin
         logic [31:0] v;
         v = 32'h12345670;
         show(k, v[4*k +: 4], 1'b0, 10);
      end
      show(0, 4'hF, 1'b0, 2);
      show(0, 4'h0, 1'b0, 10);
      blank(8);
      chk("t3_pulses", vcount - v0, 1);
      chk("t3_nib0",   {28'd0, o_value[3:0]}, 32'd0);
      chk("t3_value",  o_value, 32'h12345670);
      chk("t3_err",    {31'd0, o_err}, 32'd0);

      // blank segment pattern on digit 5
      apply_reset();
      v0 = vcount;
      for (int k = 7; k >= 0; k--) begin
         logic [31:0] v;
         v = 32'h12345678;
         if (k == 5) show_raw(5, 8'h00, 10);
         else        show(k, v[4*k +: 4], 1'b0, 10);
      end
      blank(8);
      chk("t4_err_set",  {31'd0, o_err}, 32'd1);
      chk("t4_no_pulse", vcount - v0, 0);
      show(5, 4'h3, 1'b0, 10);
      blank(8);
      chk("t4_pulses",   vcount - v0, 1);
      chk("t4_value",    o_value, 32'h12345678);
      chk("t4_err_held", {31'd0, o_err}, 32'd1);

      // reverse scan with decimal point on digit 2
      apply_reset();
      v0 = vcount;
      send_frame(32'hA0B1C2D3, 8'h04, 1'b1);
      chk("t5_pulses", vcount - v0, 1);
      chk("t5_value",  o_value, 32'hA0B1C2D3);
      chk("t5_dp",     {24'd0, o_dp}, 32'h04);

      // reset mid-frame discards partial progress
      for (int k = 7; k >= 3; k--) show(k, 4'hF, 1'b0, 10);
      reset = 1'b1;
      cycles(3);
      chk("t6_rst_value", o_value, 32'd0);
      chk("t6_rst_dp",    {24'd0, o_dp}, 32'd0);
      chk("t6_rst_valid", {31'd0, o_valid}, 32'd0);
      chk("t6_rst_err",   {31'd0, o_err}, 32'd0);
      reset = 1'b0;
      cycles(1);
      v0 = vcount;
      for (int k = 2; k >= 0; k--) show(k, 4'hF, 1'b0, 10);
      blank(8);
      chk("t6_no_pulse", vcount - v0, 0);
      for (int k = 7; k >= 3; k--) show(k, 4'hF, 1'b0, 10);
      blank(8);
      chk("t6_pulses", vcount - v0, 1);
      chk("t6_value",  o_value, 32'hFFFFFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
